// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Sequences EXE->MEM data-memory accesses through a req/ack handshake to a
// variable-latency memory, freezing the pipeline while an access is pending.
// Optional feature macro: MEM_TIMEOUT_EN (aborts an access after
// TIMEOUT_CYCLES cycles without ack and raises a sticky ERROR_OUT).

`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module mem_access_sequencer #(
  parameter int ADDR_BASE      = 1024,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 MEM_READ_EN_IN,
  input  logic                 MEM_WRITE_EN_IN,
  input  logic [`WORD_LEN-1:0] ALU_RESULT_IN,
  input  logic [`WORD_LEN-1:0] SW_OPERAND_IN,
  input  logic                 MEM_ACK,
  input  logic [`WORD_LEN-1:0] MEM_RDATA,
  output logic                 MEM_REQ,
  output logic                 MEM_WE,
  output logic [`WORD_LEN-1:0] MEM_ADDR,
  output logic [`WORD_LEN-1:0] MEM_WDATA,
  output logic [`WORD_LEN-1:0] READ_DATA_OUT,
  output logic                 FREEZE,
  output logic                 ERROR_OUT
);

  localparam int W = `WORD_LEN;

  // Reject timeout settings the 8-bit cycle counter cannot represent.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must lie in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   req_in;
  logic   timeout;

  assign req_in = MEM_READ_EN_IN | MEM_WRITE_EN_IN;

  // Byte address to word address: remove the data-segment base (modular,
  // underflow wraps silently) and drop the two byte-offset bits.
  function automatic logic [W-1:0] word_addr(input logic [W-1:0] byte_addr);
    logic [W-1:0] off;
    off = byte_addr - W'(ADDR_BASE);
    return off >> 2;
  endfunction

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt;
  logic       err_q;

  // Timeout fires on the last allowed ACCESS cycle; a same-cycle ack wins.
  assign timeout = (cnt == 8'(TIMEOUT_CYCLES - 1)) & ~MEM_ACK;

  // ACCESS cycle counter: counts unacknowledged cycles, cleared in DONE.
  always_ff @(posedge CLK) begin
    if (RESET)
      cnt <= '0;
    else if (state == DONE)
      cnt <= '0;
    else if (state == ACCESS && !MEM_ACK)
      cnt <= cnt + 8'd1;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RESET)
      err_q <= 1'b0;
    else if (state == ACCESS && timeout)
      err_q <= 1'b1;
  end

  assign ERROR_OUT = err_q;
`else
  assign timeout   = 1'b0;
  assign ERROR_OUT = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state and pipeline freeze; DONE is the single unfrozen cycle that
  // lets the pipeline move past the instruction without re-issuing it.
  always_comb begin
    state_nxt = state;
    FREEZE    = 1'b0;
    case (state)
      IDLE: begin
        if (req_in) begin
          state_nxt = ACCESS;
          FREEZE    = 1'b1;
        end
      end
      ACCESS: begin
        FREEZE = 1'b1;
        if (MEM_ACK || timeout)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request registers and held load data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MEM_REQ       <= 1'b0;
      MEM_WE        <= 1'b0;
      MEM_ADDR      <= '0;
      MEM_WDATA     <= '0;
      READ_DATA_OUT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_in) begin
            MEM_REQ   <= 1'b1;
            MEM_WE    <= MEM_WRITE_EN_IN;
            MEM_ADDR  <= word_addr(ALU_RESULT_IN);
            MEM_WDATA <= SW_OPERAND_IN;
          end
        end
        ACCESS: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            if (!MEM_WE)
              READ_DATA_OUT <= MEM_RDATA;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout) begin
            MEM_REQ <= 1'b0;
            if (!MEM_WE)
              READ_DATA_OUT <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Testbench for mem_access_sequencer: table-driven directed vectors,
// hand-written corner sequences and a randomized run against a
// transaction-level memory model.

`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module tb_mem_access_sequencer;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_READ_EN_IN, MEM_WRITE_EN_IN;
  logic [31:0] ALU_RESULT_IN, SW_OPERAND_IN;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR, MEM_WDATA, READ_DATA_OUT;
  logic        FREEZE, ERROR_OUT;

  int checks = 0;
  int errors = 0;

  logic [31:0] dmem    [16];
  logic [31:0] ref_mem [16];

  mem_access_sequencer #(.ADDR_BASE(1024), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_READ_EN_IN(MEM_READ_EN_IN), .MEM_WRITE_EN_IN(MEM_WRITE_EN_IN),
    .ALU_RESULT_IN(ALU_RESULT_IN), .SW_OPERAND_IN(SW_OPERAND_IN),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .READ_DATA_OUT(READ_DATA_OUT),
    .FREEZE(FREEZE), .ERROR_OUT(ERROR_OUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] wdata;
    int          k;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_rdo;
  } vec_t;

  function automatic vec_t mkv(input logic rd, input logic wr, input logic [31:0] alu,
                               input logic [31:0] wdata, input int k, input logic [31:0] rdata,
                               input logic [31:0] exp_addr, input logic exp_we,
                               input logic [31:0] exp_rdo);
    vec_t v;
    v.rd = rd; v.wr = wr; v.alu = alu; v.wdata = wdata; v.k = k; v.rdata = rdata;
    v.exp_addr = exp_addr; v.exp_we = exp_we; v.exp_rdo = exp_rdo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One instruction held in the EXE/MEM register until its DONE cycle.
  // k = ACCESS cycle carrying the ack (0 = never ack).
  task automatic run_instr(input string name, input logic rd, input logic wr,
                           input logic [31:0] alu, input logic [31:0] wdata,
                           input int k, input logic [31:0] rdata, input bit use_mem,
                           input logic [31:0] exp_addr, input logic exp_we,
                           input logic [31:0] exp_rdo, input logic exp_err);
    int fz, rq, cyc, exp_req;
    bit done, stable;
    logic [31:0] ad, wd;
    logic w;
    if (!rd && !wr) begin
      @(negedge CLK);
      MEM_READ_EN_IN = 1'b0; MEM_WRITE_EN_IN = 1'b0;
      ALU_RESULT_IN = alu; SW_OPERAND_IN = wdata;
      MEM_ACK = 1'($urandom_range(0, 1)); MEM_RDATA = $urandom;
      #1;
      chk($sformatf("%s.idle_freeze", name), 32'(FREEZE), 32'd0);
      chk($sformatf("%s.idle_req", name), 32'(MEM_REQ), 32'd0);
      chk($sformatf("%s.idle_rdo", name), READ_DATA_OUT, exp_rdo);
      return;
    end
    exp_req = (k == 0) ? TO : k;
    fz = 0; rq = 0; cyc = 0; done = 0; stable = 1;
    ad = '0; wd = '0; w = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge CLK);
      MEM_READ_EN_IN = rd; MEM_WRITE_EN_IN = wr;
      ALU_RESULT_IN = alu; SW_OPERAND_IN = wdata;
      if (MEM_REQ) begin
        rq++;
        MEM_ACK   = (rq == k);
        MEM_RDATA = $urandom;
        if (MEM_ACK) begin
          if (use_mem) begin
            MEM_RDATA = dmem[MEM_ADDR[3:0]];
            if (MEM_WE) dmem[MEM_ADDR[3:0]] = MEM_WDATA;
          end else begin
            MEM_RDATA = rdata;
          end
        end
      end else begin
        MEM_ACK   = 1'($urandom_range(0, 1));
        MEM_RDATA = $urandom;
      end
      #1;
      if (MEM_REQ) begin
        if (rq == 1) begin
          ad = MEM_ADDR; w = MEM_WE; wd = MEM_WDATA;
        end else if (MEM_ADDR !== ad || MEM_WE !== w || MEM_WDATA !== wd) begin
          stable = 0;
        end
      end
      if (FREEZE) fz++;
      else done = 1;
      cyc++;
    end
    chk($sformatf("%s.done_reached", name), 32'(done), 32'd1);
    chk($sformatf("%s.freeze_cycles", name), 32'(fz), 32'(exp_req + 1));
    chk($sformatf("%s.req_cycles", name), 32'(rq), 32'(exp_req));
    chk($sformatf("%s.addr", name), ad, exp_addr);
    chk($sformatf("%s.we", name), 32'(w), 32'(exp_we));
    if (exp_we) chk($sformatf("%s.wdata", name), wd, wdata);
    chk($sformatf("%s.stable", name), 32'(stable), 32'd1);
    chk($sformatf("%s.rdo", name), READ_DATA_OUT, exp_rdo);
    chk($sformatf("%s.err", name), 32'(ERROR_OUT), 32'(exp_err));
  endtask

  initial begin
    vec_t vt[8];
    logic [31:0] cur_rdo;

    vt[0] = mkv(1, 0, 32'd1032, 32'h0,         3, 32'h1234_5678, 32'd2,         0, 32'h1234_5678);
    vt[1] = mkv(0, 1, 32'd1028, 32'hCAFE_F00D, 1, 32'h0,         32'd1,         1, 32'h1234_5678);
    vt[2] = mkv(1, 1, 32'd1024, 32'hA5A5_A5A5, 2, 32'h1111_1111, 32'd0,         1, 32'h1234_5678);
    vt[3] = mkv(1, 0, 32'd0,    32'h0,         1, 32'hDEAD_BEEF, 32'h3FFF_FF00, 0, 32'hDEAD_BEEF);
    vt[4] = mkv(0, 0, 32'd1500, 32'h0,         0, 32'h0,         32'd0,         0, 32'hDEAD_BEEF);
    vt[5] = mkv(1, 0, 32'd1027, 32'h0,         4, 32'h0BAD_F00D, 32'd0,         0, 32'h0BAD_F00D);
    vt[6] = mkv(0, 1, 32'd2047, 32'h55AA_55AA, 2, 32'h0,         32'd255,       1, 32'h0BAD_F00D);
    vt[7] = mkv(1, 0, 32'd1424, 32'h0,         1, 32'h0000_0001, 32'd100,       0, 32'h0000_0001);

    RESET = 1'b1;
    MEM_READ_EN_IN = 1'b0; MEM_WRITE_EN_IN = 1'b0;
    ALU_RESULT_IN = '0; SW_OPERAND_IN = '0;
    MEM_ACK = 1'b0; MEM_RDATA = '0;

    // Reset values
    repeat (3) @(negedge CLK);
    #1;
    chk("rst.req", 32'(MEM_REQ), 32'd0);
    chk("rst.we", 32'(MEM_WE), 32'd0);
    chk("rst.addr", MEM_ADDR, 32'd0);
    chk("rst.wdata", MEM_WDATA, 32'd0);
    chk("rst.rdo", READ_DATA_OUT, 32'd0);
    chk("rst.err", 32'(ERROR_OUT), 32'd0);
    chk("rst.freeze_idle", 32'(FREEZE), 32'd0);
    MEM_READ_EN_IN = 1'b1;
    #1;
    chk("rst.freeze_follows_rd", 32'(FREEZE), 32'd1);
    MEM_READ_EN_IN = 1'b0;
    #1;
    chk("rst.freeze_drops", 32'(FREEZE), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Directed vectors, issued back-to-back
    for (int i = 0; i < 8; i++)
      run_instr($sformatf("vec%0d", i), vt[i].rd, vt[i].wr, vt[i].alu, vt[i].wdata,
                vt[i].k, vt[i].rdata, 1'b0, vt[i].exp_addr, vt[i].exp_we, vt[i].exp_rdo, 1'b0);

`ifdef MEM_TIMEOUT_EN
    // Load with no ack: aborted after TO cycles, data zeroed, error sticky
    run_instr("timeout_load", 1, 0, 32'd1036, 32'h0, 0, 32'h0, 1'b0, 32'd3, 0, 32'h0, 1'b1);
    run_instr("after_to_store", 0, 1, 32'd1040, 32'h1357_9BDF, 1, 32'h0, 1'b0, 32'd4, 1, 32'h0, 1'b1);
    run_instr("after_to_load", 1, 0, 32'd1044, 32'h0, 2, 32'h0000_0077, 1'b0, 32'd5, 0, 32'h0000_0077, 1'b1);
`endif

    // Reset in the 2nd ACCESS cycle, then a late ack
    @(negedge CLK);
    MEM_READ_EN_IN = 1'b1; MEM_WRITE_EN_IN = 1'b0; ALU_RESULT_IN = 32'd1040; MEM_ACK = 1'b0;
    #1;
    chk("rstmid.freeze_idle", 32'(FREEZE), 32'd1);
    @(negedge CLK);
    MEM_ACK = 1'b0;
    #1;
    chk("rstmid.req_acc1", 32'(MEM_REQ), 32'd1);
    @(negedge CLK);
    RESET = 1'b1; MEM_ACK = 1'b0;
    #1;
    chk("rstmid.req_acc2", 32'(MEM_REQ), 32'd1);
    @(negedge CLK);
    RESET = 1'b0; MEM_READ_EN_IN = 1'b0; MEM_ACK = 1'b1; MEM_RDATA = 32'hFFFF_FFFF;
    #1;
    chk("rstmid.req", 32'(MEM_REQ), 32'd0);
    chk("rstmid.we", 32'(MEM_WE), 32'd0);
    chk("rstmid.addr", MEM_ADDR, 32'd0);
    chk("rstmid.wdata", MEM_WDATA, 32'd0);
    chk("rstmid.rdo", READ_DATA_OUT, 32'd0);
    chk("rstmid.err", 32'(ERROR_OUT), 32'd0);
    chk("rstmid.freeze", 32'(FREEZE), 32'd0);
    @(negedge CLK);
    MEM_ACK = 1'b0;
    #1;
    chk("rstmid.late_ack_rdo", READ_DATA_OUT, 32'd0);
    chk("rstmid.late_ack_req", 32'(MEM_REQ), 32'd0);

    // Randomized traffic against a word-array memory model
    for (int i = 0; i < 16; i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    cur_rdo = 32'h0;
    for (int n = 0; n < 40; n++) begin
      int op, idx, k;
      logic [31:0] alu, wd;
      logic is_store;
      op  = $urandom_range(0, 3);
      idx = $urandom_range(0, 15);
      k   = $urandom_range(1, TO);
      alu = 32'(1024 + idx * 4 + $urandom_range(0, 3));
      wd  = $urandom;
      is_store = (op >= 2);
      if (op == 1) cur_rdo = ref_mem[idx];
      if (is_store) ref_mem[idx] = wd;
      run_instr($sformatf("rnd%0d", n), op[0], op[1], alu, wd, k, 32'h0, 1'b1,
                32'(idx), is_store, cur_rdo, 1'b0);
    end

    run_instr("final_idle", 0, 0, 32'd0, 32'd0, 0, 32'h0, 1'b0, 32'd0, 0, cur_rdo, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
